iir_cascade_seq: RTL and testbench

Time-multiplexed sequencer for a cascade of NUM_SEC second-order IIR sections sharing one 32x32 multiplier. It accepts one sample per valid/ready handshake, runs it through every section in order, and presents the result with a held valid/ready output. It owns the per-section coefficient bank and the delay state, and sits between the sample source and the downstream consumer in the low-pass filter chain.

---
 rtl/iir_seq_pkg.sv | 37 +++
 rtl/iir_coef_bank.sv | 35 +++
 rtl/iir_cascade_seq.sv | 144 ++++++++++++++
 tb/tb_iir_cascade_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_seq_pkg.sv
// Shared types and constants for the time-multiplexed biquad cascade sequencer.
package iir_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL_S,
    MUL_A2,
    MUL_A3,
    MUL_B2,
    UPD,
    OUT
  } state_e;

  typedef enum logic [1:0] {
    SEL_S  = 2'd0,
    SEL_A2 = 2'd1,
    SEL_A3 = 2'd2,
    SEL_B2 = 2'd3
  } cfg_sel_e;

  localparam int COEF_S_DEF  = 1022;
  localparam int COEF_A2_DEF = -3528;
  localparam int COEF_A3_DEF = 1778;
  localparam int COEF_B2_DEF = -2824;
  localparam int FRAC_DEF    = 11;
  localparam int MAX_SEC     = 8;

  function automatic int def_coef(input cfg_sel_e sel);
    case (sel)
      SEL_A2:  return COEF_A2_DEF;
      SEL_A3:  return COEF_A3_DEF;
      SEL_B2:  return COEF_B2_DEF;
      default: return COEF_S_DEF;
    endcase
  endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// Per-section coefficient register file: one write port, combinational read by (sec, sel).
module iir_coef_bank
  import iir_seq_pkg::*;
#(
  parameter int NO_BITS = 32
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      we,
  input  logic [2:0]                wsec,
  input  logic [1:0]                wsel,
  input  logic signed [NO_BITS-1:0] wdata,
  input  logic [2:0]                rsec,
  input  logic [1:0]                rsel,
  output logic signed [NO_BITS-1:0] rdata
);

  // Sized for the full 3-bit section index so every index is in range.
  logic signed [NO_BITS-1:0] coef [MAX_SEC][4];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < MAX_SEC; k++) begin
        for (int j = 0; j < 4; j++) begin
          coef[k][j] <= NO_BITS'(def_coef(cfg_sel_e'(j)));
        end
      end
    end else if (we) begin
      coef[wsec][wsel] <= wdata;
    end
  end

  assign rdata = coef[rsec][rsel];

endmodule

// File: rtl/iir_cascade_seq.sv
// Cascade of NUM_SEC biquad sections sharing one multiplier, one product per cycle.
// Define IIR_SAT_EN to clamp partial sums, w and y instead of wrapping.
module iir_cascade_seq
  import iir_seq_pkg::*;
#(
  parameter int NO_BITS = 32,
  parameter int NUM_SEC = 4,
  parameter int FRAC    = FRAC_DEF
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic signed [NO_BITS-1:0] in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [NO_BITS-1:0] out,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      cfg_we,
  input  logic [2:0]                cfg_sec,
  input  logic [1:0]                cfg_sel,
  input  logic signed [NO_BITS-1:0] cfg_data,
  output logic                      cfg_err,
  output logic                      busy
);

  localparam int         PW       = 2 * NO_BITS;
  localparam logic [2:0] LAST_SEC = 3'(NUM_SEC - 1);
  localparam logic [3:0] SEC_LIM  = 4'(NUM_SEC);

  state_e                    state;
  logic [2:0]                sec;
  logic signed [NO_BITS-1:0] d1 [MAX_SEC];
  logic signed [NO_BITS-1:0] d2 [MAX_SEC];
  logic signed [NO_BITS-1:0] x, acc, w_hold;
  logic signed [NO_BITS-1:0] opa, coef, base, y_upd;
  cfg_sel_e                  rsel;
  logic                      neg, cfg_ok, cfg_wr;
  logic signed [PW-1:0]      prod, term;
  logic signed [PW:0]        sum_w, upd_w;

`ifdef IIR_SAT_EN
  localparam logic signed [PW:0] SAT_HI = {{(PW-NO_BITS+2){1'b0}}, {(NO_BITS-1){1'b1}}};
  localparam logic signed [PW:0] SAT_LO = {{(PW-NO_BITS+2){1'b1}}, {(NO_BITS-1){1'b0}}};
`endif

  function automatic logic signed [NO_BITS-1:0] fit(input logic signed [PW:0] v);
`ifdef IIR_SAT_EN
    if (v > SAT_HI) return {1'b0, {(NO_BITS-1){1'b1}}};
    if (v < SAT_LO) return {1'b1, {(NO_BITS-1){1'b0}}};
`endif
    return v[NO_BITS-1:0];
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign cfg_ok   = ({1'b0, cfg_sec} < SEC_LIM);
  assign cfg_wr   = cfg_we && cfg_ok && (state == IDLE);

  iir_coef_bank #(.NO_BITS(NO_BITS)) u_bank (
    .CLK   (CLK),
    .reset (reset),
    .we    (cfg_wr),
    .wsec  (cfg_sec),
    .wsel  (cfg_sel),
    .wdata (cfg_data),
    .rsec  (sec),
    .rsel  (rsel),
    .rdata (coef)
  );

  // Operand and accumulate-direction select for the shared multiplier.
  always_comb begin
    opa  = x;
    rsel = SEL_S;
    neg  = 1'b0;
    case (state)
      MUL_A2: begin opa = d1[sec]; rsel = SEL_A2; neg = 1'b1; end
      MUL_A3: begin opa = d2[sec]; rsel = SEL_A3; neg = 1'b1; end
      MUL_B2: begin opa = d1[sec]; rsel = SEL_B2; end
      default: ;
    endcase
  end

  assign prod  = PW'(opa) * PW'(coef);
  assign term  = prod >>> FRAC;
  assign base  = (state == MUL_S) ? '0 : acc;
  assign sum_w = neg ? ((PW+1)'(base) - (PW+1)'(term)) : ((PW+1)'(base) + (PW+1)'(term));
  assign upd_w = (PW+1)'(acc) + (PW+1)'(d2[sec]);
  assign y_upd = fit(upd_w);

  // Control, delay state and output registers.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sec       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
      for (int k = 0; k < MAX_SEC; k++) begin
        d1[k] <= '0;
        d2[k] <= '0;
      end
    end else begin
      cfg_err <= cfg_we && ((state != IDLE) || !cfg_ok);
      case (state)
        IDLE: if (in_valid) begin
          state <= MUL_S;
          sec   <= '0;
        end
        MUL_S:  state <= MUL_A2;
        MUL_A2: state <= MUL_A3;
        MUL_A3: state <= MUL_B2;
        MUL_B2: state <= UPD;
        UPD: begin
          d2[sec] <= d1[sec];
          d1[sec] <= w_hold;
          if (sec == LAST_SEC) begin
            state     <= OUT;
            out       <= y_upd;
            out_valid <= 1'b1;
          end else begin
            state <= MUL_S;
            sec   <= sec + 3'd1;
          end
        end
        OUT: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge CLK) begin
    if (state == IDLE && in_valid) x <= in;
    if (state == UPD) x <= y_upd;
    if (state == MUL_S || state == MUL_A2 || state == MUL_A3 || state == MUL_B2)
      acc <= fit(sum_w);
    if (state == MUL_B2) w_hold <= acc;
  end

endmodule

// File: tb/tb_iir_cascade_seq.sv
// Directed bench for iir_cascade_seq: one single-section and one four-section instance.
module tb_iir_cascade_seq;

  logic               clk, reset_n;
  logic signed [31:0] in1, out1, in4, out4, cfg_data;
  logic               iv1, ir1, ov1, or1, err1, busy1;
  logic               iv4, ir4, ov4, or4, err4, busy4;
  logic               cfg_we;
  logic [2:0]         cfg_sec;
  logic [1:0]         cfg_sel;

  int n_chk = 0;
  int n_fail = 0;

  longint m_d1 [4];
  longint m_d2 [4];
  longint m_c  [4][4];

  iir_cascade_seq #(.NO_BITS(32), .NUM_SEC(1), .FRAC(11)) dut1 (
    .CLK(clk), .reset(reset_n), .in(in1), .in_valid(iv1), .in_ready(ir1),
    .out(out1), .out_valid(ov1), .out_ready(or1), .cfg_we(cfg_we),
    .cfg_sec(cfg_sec), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .cfg_err(err1), .busy(busy1)
  );

  iir_cascade_seq #(.NO_BITS(32), .NUM_SEC(4), .FRAC(11)) dut4 (
    .CLK(clk), .reset(reset_n), .in(in4), .in_valid(iv4), .in_ready(ir4),
    .out(out4), .out_valid(ov4), .out_ready(or4), .cfg_we(cfg_we),
    .cfg_sec(cfg_sec), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .cfg_err(err4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint mfit(input longint v);
`ifdef IIR_SAT_EN
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
`else
    return longint'(int'(v));
`endif
  endfunction

  function automatic longint mprod(input longint a, input longint b);
    return (a * b) >>> 11;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_d1[k] = 0;
      m_d2[k] = 0;
      m_c[k][0] = 1022;
      m_c[k][1] = -3528;
      m_c[k][2] = 1778;
      m_c[k][3] = -2824;
    end
  endtask

  task automatic model_step(input longint xin, output longint yout);
    longint xs, acc, w;
    xs = xin;
    for (int k = 0; k < 4; k++) begin
      acc = mfit(mprod(xs, m_c[k][0]));
      acc = mfit(acc - mprod(m_d1[k], m_c[k][1]));
      w   = mfit(acc - mprod(m_d2[k], m_c[k][2]));
      acc = mfit(w + mprod(m_d1[k], m_c[k][3]));
      xs  = mfit(acc + m_d2[k]);
      m_d2[k] = m_d1[k];
      m_d1[k] = w;
    end
    yout = xs;
  endtask

  task automatic run1(input logic signed [31:0] v, output logic signed [31:0] got);
    int n;
    @(negedge clk);
    for (int i = 0; i < 4 && !ir1; i++) @(negedge clk);
    in1 = v;
    iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    n = 0;
    while (!ov1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("sec1_valid", ov1, 1);
    got = out1;
  endtask

  task automatic run4(input logic signed [31:0] v, input int stall, input int cfg_at,
                      input logic [2:0] cs, input logic [1:0] cl, input logic signed [31:0] cd,
                      output logic signed [31:0] got, output int lat, output int errs,
                      output longint s_obs);
    int rdy_hi, unstable;
    logic signed [31:0] held;
    @(negedge clk);
    for (int i = 0; i < 4 && !ir4; i++) @(negedge clk);
    in4 = v;
    iv4 = 1'b1;
    if (cfg_at == 0) begin
      cfg_we = 1'b1; cfg_sec = cs; cfg_sel = cl; cfg_data = cd;
    end
    @(posedge clk); #1;
    iv4 = 1'b0;
    cfg_we = 1'b0;
    lat = 1;
    rdy_hi = 0;
    errs = err4 ? 1 : 0;
    s_obs = 0;
    while (!ov4 && lat < 300) begin
      if (ir4) rdy_hi++;
      if (lat == 2) s_obs = dut4.acc;
      if (lat == cfg_at) begin
        cfg_we = 1'b1; cfg_sec = cs; cfg_sel = cl; cfg_data = cd;
      end
      @(posedge clk); #1;
      lat++;
      cfg_we = 1'b0;
      if (err4) errs++;
    end
    check("ready_low_in_compute", rdy_hi, 0);
    check("out_valid_seen", ov4, 1);
    got = out4;
    held = out4;
    unstable = 0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (out4 !== held || !ov4 || ir4 || !busy4) unstable++;
    end
    check("stall_hold", unstable, 0);
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0;
    check("out_valid_clear", ov4, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic signed [31:0] got;
    longint exp_y, s_obs;
    int lat, errs, early, nz;

    reset_n = 1'b0;
    in1 = '0; iv1 = 1'b0; or1 = 1'b1;
    in4 = '0; iv4 = 1'b0; or4 = 1'b0;
    cfg_we = 1'b0; cfg_sec = '0; cfg_sel = '0; cfg_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    check("rst_out_valid", ov4, 0);
    check("rst_out", out4, 0);
    check("rst_cfg_err", err4, 0);
    check("rst_in_ready", ir4, 1);
    check("rst_busy", busy4, 0);
    check("rst_out_valid_sec1", ov1, 0);

    // Single section with default coefficients.
    run1(32'sd2048, got);
    check("sec1_y0", got, 1022);
    run1(32'sd0, got);
    check("sec1_y1", got, 351);

    // Four sections: latency and value.
    run4(32'sd2048, 0, -1, 3'd0, 2'd0, 32'sd0, got, lat, errs, s_obs);
    model_step(2048, exp_y);
    check("latency", lat, 21);
    check("y_2048", got, exp_y);

    // Output stall, then the following sample against the model.
    run4(-32'sd5000, 10, -1, 3'd0, 2'd0, 32'sd0, got, lat, errs, s_obs);
    model_step(-5000, exp_y);
    check("y_stalled", got, exp_y);
    run4(32'sd12345, 0, -1, 3'd0, 2'd0, 32'sd0, got, lat, errs, s_obs);
    model_step(12345, exp_y);
    check("y_after_stall", got, exp_y);

    // Write during MUL_A3 is dropped.
    run4(32'sd300, 0, 3, 3'd0, 2'd0, 32'sd2048, got, lat, errs, s_obs);
    model_step(300, exp_y);
    check("busy_cfg_err_pulses", errs, 1);
    check("y_coef_unchanged", got, exp_y);

    // Out-of-range section index in IDLE is dropped.
    @(negedge clk);
    cfg_we = 1'b1; cfg_sec = 3'd5; cfg_sel = 2'd1; cfg_data = 32'sd7;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("badsec_cfg_err", err4, 1);
    @(posedge clk); #1;
    check("badsec_cfg_err_clear", err4, 0);

    // s = 2048 written in the same IDLE cycle the sample is accepted.
    m_c[0][0] = 2048;
    run4(32'sd100, 0, 0, 3'd0, 2'd0, 32'sd2048, got, lat, errs, s_obs);
    model_step(100, exp_y);
    check("s_stage_unity", s_obs, 100);
    check("idle_cfg_no_err", errs, 0);
    check("y_new_s", got, exp_y);

    // Reset asserted during UPD of section 2.
    @(negedge clk);
    in4 = 32'sd777;
    iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    early = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (ov4) early++;
    end
    check("abort_no_early_valid", early, 0);
    check("abort_busy_before", busy4, 1);
    reset_n = 1'b0;
    #1;
    nz = 0;
    for (int k = 0; k < 4; k++) begin
      if (dut4.d1[k] != 0 || dut4.d2[k] != 0) nz++;
    end
    check("abort_state_zero", nz, 0);
    check("abort_out_valid", ov4, 0);
    check("abort_out", out4, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("abort_still_no_valid", ov4, 0);
    run4(32'sd777, 0, -1, 3'd0, 2'd0, 32'sd0, got, lat, errs, s_obs);
    model_step(777, exp_y);
    check("y_after_abort", got, exp_y);

    // Overflow at section 0 with s = 4095.
    pulse_reset();
    m_c[0][0] = 4095;
    run4(32'sh7FFFFFFF, 0, 0, 3'd0, 2'd0, 32'sd4095, got, lat, errs, s_obs);
    model_step(64'sd2147483647, exp_y);
`ifdef IIR_SAT_EN
    check("sec0_w_overflow", dut4.d1[0], 64'sd2147483647);
`else
    check("sec0_w_overflow", dut4.d1[0], -64'sd1048578);
`endif
    check("y_overflow", got, exp_y);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
